// File: rtl/led_fade_driver.sv
// led_fade_driver: turns the blinker's active-low on/off level into a PWM LED drive
// that fades in and out instead of switching hard.
// Optional build macro LED_FADE_GAMMA_EN: maps duty through a squared curve before
// it reaches the PWM comparator. The duty port stays linear in both builds.
module led_fade_driver #(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 97_656
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                led_in,
    input  logic                enable,
    output logic                led_out,
    output logic [PWM_BITS-1:0] duty,
    output logic                busy
);

    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] ZERO_V    = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] ONE_V     = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] MAX_V     = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] MAX_M1_V  = MAX_V - ONE_V;
    localparam logic [STEP_W-1:0]   STEP_ZERO = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0]   STEP_ONE  = STEP_W'(1);
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_FADE_UP   = 2'd1,
        ST_ON        = 2'd2,
        ST_FADE_DOWN = 2'd3
    } state_t;

    logic                sync1_r;
    logic                sync2_r;
    logic                req_on_s;
    state_t              state_r;
    state_t              state_s;
    logic [PWM_BITS-1:0] duty_r;
    logic [PWM_BITS-1:0] duty_s;
    logic [STEP_W-1:0]   step_cnt_r;
    logic [STEP_W-1:0]   step_cnt_s;
    logic                tick_s;
    logic                busy_r;
    logic                busy_s;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [PWM_BITS-1:0] duty_lat_r;
    logic [PWM_BITS-1:0] level_s;
    logic                led_out_r;

    // Two-flop synchronizer for the asynchronous blinker level (idles high = LED off)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= led_in;
            sync2_r <= sync1_r;
        end
    end

    assign req_on_s = ~sync2_r;
    assign tick_s   = (step_cnt_r == STEP_LAST);

    // State register together with the ramp level, prescaler and busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_OFF;
            duty_r     <= ZERO_V;
            step_cnt_r <= STEP_ZERO;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            duty_r     <= duty_s;
            step_cnt_r <= step_cnt_s;
            busy_r     <= busy_s;
        end
    end

    // Next-state logic: enable has top priority, a direction change beats a step tick
    always_comb begin
        state_s    = state_r;
        duty_s     = duty_r;
        step_cnt_s = step_cnt_r;
        if (!enable) begin
            state_s    = ST_OFF;
            duty_s     = ZERO_V;
            step_cnt_s = STEP_ZERO;
        end else begin
            case (state_r)
                ST_OFF: begin
                    duty_s     = ZERO_V;
                    step_cnt_s = STEP_ZERO;
                    if (req_on_s) begin
                        state_s = ST_FADE_UP;
                    end else begin
                        state_s = ST_OFF;
                    end
                end
                ST_FADE_UP: begin
                    if (!req_on_s) begin
                        state_s    = ST_FADE_DOWN;
                        step_cnt_s = STEP_ZERO;
                    end else if (tick_s) begin
                        step_cnt_s = STEP_ZERO;
                        if (duty_r >= MAX_M1_V) begin
                            duty_s  = MAX_V;
                            state_s = ST_ON;
                        end else begin
                            duty_s = duty_r + ONE_V;
                        end
                    end else begin
                        step_cnt_s = step_cnt_r + STEP_ONE;
                    end
                end
                ST_ON: begin
                    duty_s     = MAX_V;
                    step_cnt_s = STEP_ZERO;
                    if (!req_on_s) begin
                        state_s = ST_FADE_DOWN;
                    end else begin
                        state_s = ST_ON;
                    end
                end
                ST_FADE_DOWN: begin
                    if (req_on_s) begin
                        state_s    = ST_FADE_UP;
                        step_cnt_s = STEP_ZERO;
                    end else if (tick_s) begin
                        step_cnt_s = STEP_ZERO;
                        if (duty_r <= ONE_V) begin
                            duty_s  = ZERO_V;
                            state_s = ST_OFF;
                        end else begin
                            duty_s = duty_r - ONE_V;
                        end
                    end else begin
                        step_cnt_s = step_cnt_r + STEP_ONE;
                    end
                end
                default: begin
                    state_s    = ST_OFF;
                    duty_s     = ZERO_V;
                    step_cnt_s = STEP_ZERO;
                end
            endcase
        end
    end

    // Output decode: busy follows the state it will be registered with
    always_comb begin
        if ((state_s == ST_FADE_UP) || (state_s == ST_FADE_DOWN)) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
    end

`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] duty_sq_s;

    // Squared brightness curve; full scale is pinned so ON is lit continuously
    always_comb begin
        duty_sq_s = {{PWM_BITS{1'b0}}, duty_r} * {{PWM_BITS{1'b0}}, duty_r};
        if (duty_r == MAX_V) begin
            level_s = MAX_V;
        end else begin
            level_s = duty_sq_s[2*PWM_BITS-1:PWM_BITS];
        end
    end
`else
    // Linear brightness: PWM level equals the ramp value
    always_comb begin
        level_s = duty_r;
    end
`endif

    // PWM period counter, MAX cycles per period; compare level is reloaded only at
    // period end so a changing duty never produces a runt pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_r  <= ZERO_V;
            duty_lat_r <= ZERO_V;
            led_out_r  <= 1'b1;
        end else begin
            if (pwm_cnt_r == MAX_M1_V) begin
                pwm_cnt_r <= ZERO_V;
            end else begin
                pwm_cnt_r <= pwm_cnt_r + ONE_V;
            end
            if (!enable) begin
                duty_lat_r <= ZERO_V;
            end else if (pwm_cnt_r == MAX_M1_V) begin
                duty_lat_r <= level_s;
            end else begin
                duty_lat_r <= duty_lat_r;
            end
            led_out_r <= ~(pwm_cnt_r < duty_lat_r);
        end
    end

    assign led_out = led_out_r;
    assign duty    = duty_r;
    assign busy    = busy_r;

endmodule
